inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage in front of if_id, and therefore upstream of the decode stage.
- Owns the PC and issues in-order requests on a req/gnt/rvalid instruction-memory bus.
- Buffers returned words in a small FIFO and presents {address, instruction} to if_id with a valid flag.
- Honours a pipeline stall; on a jump redirect, discards all in-flight fetches.

Parameters:
- ADDR_W, 32, instruction address width (matches `ADDR_WIDTH).
- DATA_W, 32, instruction width (matches `DATA_WIDTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch-buffer entries; also the cap on outstanding + buffered fetches (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; one clock, asynchronous active-low reset
- stall_i  in  1  downstream hold; head instruction must not be consumed
- jump_en_i  in  1  redirect request (branch/jump resolved in exe)
- jump_addr_i  in  ADDR_W  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  fetch address (always word-aligned)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses arrive in order, at least 1 cycle after gnt
- imem_rdata_i  in  DATA_W  response instruction
- inst_valid_o  out  1  head entry valid, to if_id
- inst_addr_o  out  ADDR_W  head instruction address
- inst_o  out  DATA_W  head instruction; `NOP (32'h0000_0013) when not valid

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard_cnt=0, FIFO empty.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_addr_o=0, inst_o=`NOP.
- FSM states:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: normal fetching.
  - FLUSH: draining stale responses.
- Request issue:
  - imem_req_o=1 only in RUN, when jump_en_i=0 and (outstanding + fifo_count) < FIFO_DEPTH. Registered counts only; no same-cycle pop credit.
  - imem_addr_o=pc.
  - On req&&gnt: pc<=pc+4 (mod 2^ADDR_W, wraps silently) and outstanding++.
- Response capture:
  - rvalid with discard_cnt==0: outstanding--, push {resp_pc, rdata} into the FIFO, resp_pc<=resp_pc+4.
  - rvalid with discard_cnt>0: outstanding--, discard_cnt--, no push.
  - rvalid with outstanding==0 is a protocol error; ignore it (no push) and flag it with an assertion.
- Output and pop:
  - inst_valid_o = FIFO non-empty. inst_addr_o and inst_o come from the head, combinationally from FIFO registers.
  - Latency: rvalid at cycle N gives inst_valid_o at N+1. No bypass.
  - Pop when inst_valid_o && !stall_i && !jump_en_i.
  - Stall holds head addr and data stable for any duration.
  - Push and pop in the same cycle on a full FIFO is legal. Overflow is impossible by the credit rule.
- Redirect (jump_en_i=1; highest priority, accepted in any state except IDLE):
  - The FIFO is cleared. No pop and no push that cycle; a same-cycle rvalid is stale.
  - pc<=resp_pc<={jump_addr_i[ADDR_W-1:2],2'b00}.
  - discard_cnt<=outstanding − (rvalid ? 1 : 0).
  - Next state is FLUSH if that value is >0, else RUN.
  - imem_req_o is forced 0 that cycle.
- FLUSH:
  - No requests are issued.
  - On each rvalid: discard and decrement. Go to RUN in the cycle after discard_cnt reaches 0.
  - A jump_en_i during FLUSH re-targets pc and resp_pc and recomputes discard_cnt from outstanding.
- A redirect in IDLE is ignored.
- Reset asserted mid-operation clears everything immediately. Memory is required to be reset by the same rst_n_i, so no stale responses remain after reset.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched_o [31:0], which counts pops.
  - Adds perf_bubble_o [31:0], which counts RUN/FLUSH cycles with !inst_valid_o && !stall_i.
  - Both are reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- defines.v gains `RESET_PC, the `FETCH_IDLE/`FETCH_RUN/`FETCH_FLUSH 2-bit encodings and `INST_FETCH_PERF_EN documentation.
- It reuses the existing `NOP, `ADDR_WIDTH and `DATA_WIDTH.
- One sub-module, fetch_fifo: synchronous FIFO, width ADDR_W+DATA_W, parameter DEPTH, async active-low reset, push/pop/clear, count/empty/full, head data.
- inst_fetch holds the FSM, pc, resp_pc, outstanding and discard counters.

Test Plan:
- Reset then free run, gnt=1, 1-cycle rvalid, rdata=addr^32'hA5A5_0000:
  - first req is at addr 0 on the 2nd cycle after release.
  - inst_valid_o/inst_addr_o show 0, 4, 8, … back-to-back with matching data.
- Stall held 5 cycles with the FIFO full:
  - head stays at addr 8.
  - imem_req_o=0 while outstanding+count=2.
  - no lost or duplicated instruction after release.
- Redirect to 32'h0000_0103 with 2 outstanding:
  - next req addr is 0x100.
  - both stale responses are dropped (state FLUSH for 2 rvalids).
  - first delivered instruction has addr 0x100.
- Redirect coincident with rvalid and with stall_i=1:
  - no push and no pop.
  - discard_cnt=outstanding−1.
  - FIFO empty the next cycle.
- gnt withheld 3 cycles, then rvalid delayed 4 cycles:
  - imem_addr_o stays stable while req is ungranted.
  - order is preserved.
- PC wrap, with RESET_PC=32'hFFFF_FFF8:
  - fetch sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Perf build (INST_FETCH_PERF_EN):
  - perf_fetched_o is 3 after 3 pops.
  - perf_bubble_o counts the empty cycles after a redirect.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: bus widths, the NOP
// encoding presented when no instruction is available, and the 2-bit
// fetch FSM state encodings.
package inst_fetch_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Fetch FSM encodings
    localparam logic [1:0] FETCH_IDLE  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_FLUSH = 2'd2;

    typedef logic [1:0] fetch_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding {address, instruction} pairs
// returned from instruction memory. The head entry is read combinationally
// from the storage registers so the fetch stage can present it without an
// extra cycle. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_eff;
    logic             pop_eff;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle
    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign pop_eff  = pop_i && !empty_o && !clear_i;
    assign push_eff = push_i && (!full_o || pop_eff) && !clear_i;
    assign count_o  = count_q;
    assign rdata_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    // Storage entries carry no reset; validity is tracked by count_q alone
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (push_eff && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage feeding if_id. Owns the PC, issues
// in-order req/gnt/rvalid fetches, buffers responses in fetch_fifo and
// presents the head {address, instruction} with a valid flag. A redirect
// clears the buffer and discards every response still in flight.
// Optional build macro INST_FETCH_PERF_EN adds pop and bubble counters.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [DATA_W-1:0] inst_o
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_bubble_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ENT_W-1:0]  fifo_head;

    logic              credit;
    logic              fire;
    logic              rsp_ok;
    logic              redirect;
    logic [ADDR_W-1:0] jump_target;

    // Credit uses registered counts only, so the FIFO can never overflow
    assign credit = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req_o  = (state_q == FETCH_RUN) && !jump_en_i && credit;
    assign imem_addr_o = pc_q;
    assign fire        = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a bus protocol error and is dropped
    assign rsp_ok      = imem_rvalid_i && (outstanding_q != '0);
    assign redirect    = jump_en_i && (state_q != FETCH_IDLE);
    assign jump_target = jump_addr_i & ~ADDR_W'(3);

    assign inst_valid_o = !fifo_empty;
    assign inst_addr_o  = fifo_empty ? '0 : fifo_head[ENT_W-1:DATA_W];
    assign inst_o       = fifo_empty ? DATA_W'(NOP) : fifo_head[DATA_W-1:0];

    // Next-state logic: FSM, PC, response PC, outstanding and discard counters
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(rsp_ok);
        fifo_push     = 1'b0;
        fifo_clear    = 1'b0;
        fifo_pop      = !fifo_empty && !stall_i && !jump_en_i;

        if (fire) pc_d = pc_q + ADDR_W'(4);

        if (state_q == FETCH_IDLE) begin
            state_d = FETCH_RUN;
        end else if (redirect) begin
            // Everything in flight, including a same-cycle response, is stale
            fifo_clear = 1'b1;
            pc_d       = jump_target;
            resp_pc_d  = jump_target;
            discard_d  = outstanding_q - CNT_W'(rsp_ok);
            state_d    = (discard_d != '0) ? FETCH_FLUSH : FETCH_RUN;
        end else begin
            if (rsp_ok) begin
                if (discard_q == '0) begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + ADDR_W'(4);
                end else begin
                    discard_d = discard_q - CNT_W'(1);
                end
            end
            if ((state_q == FETCH_FLUSH) && (discard_d == '0)) state_d = FETCH_RUN;
        end
    end

    // Fetch control registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({resp_pc_q, imem_rdata_i}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    a_rvalid_with_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) imem_rvalid_i |-> (outstanding_q != '0));

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) (fifo_full && fifo_push) |-> fifo_pop);

`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubble_q;

    // Pops delivered to decode, and active cycles where decode was starved
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            if (fifo_pop) perf_fetched_q <= perf_fetched_q + 32'd1;
            if ((state_q != FETCH_IDLE) && !inst_valid_o && !stall_i) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_bubble_o  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a behavioural memory plus a queue-based model
// of the delivered instruction stream, checked every cycle, and a few
// hand-computed expectations from directed scenarios.
module tb_inst_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_W    = 32'h0000_0013;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        stall_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_bubble_o;
`endif

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .stall_i       (stall_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_addr_o   (inst_addr_o),
        .inst_o        (inst_o)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched_o),
        .perf_bubble_o  (perf_bubble_o)
`endif
    );

    // Memory-side record of a granted fetch: address, redirect epoch, return cycle
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } pend_t;

    pend_t       pend[$];     // granted, not yet returned (in order)
    logic [31:0] mq[$];       // addresses buffered for decode
    logic [31:0] glog[$];     // granted fetch addresses seen on the bus
    logic [31:0] plog[$];     // addresses consumed by decode
    logic [31:0] m_pc;
    int          m_epoch;
    bit          m_idle;
    int          m_pops;
    int          m_bubbles;
    int          cyc;
    int          first_req_cyc;
    int          first_pop_cyc;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entered and left at a falling edge; drives one cycle, checks, advances the model
    task automatic step(input bit st, input bit jmp, input logic [31:0] jaddr,
                        input int gnt_pct, input int lat_lo, input int lat_hi,
                        input bit jump_on_rv, output bit jumped);
        bit    rv;
        bit    req_e;
        bit    valid_e;
        bit    do_pop;
        bit    jeff;
        int    stale;
        pend_t r;

        stall_i     = st;
        jump_en_i   = jmp;
        jump_addr_i = jaddr;
        imem_gnt_i  = ($urandom_range(0, 99) < gnt_pct);
        rv = (pend.size() > 0) && (pend[0].ready <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? (pend[0].addr ^ DATA_KEY) : $urandom();
        if (jump_on_rv && rv) jump_en_i = 1'b1;
        jumped = jump_en_i;
        #1;

        valid_e = (mq.size() > 0);
        chk("inst_valid", inst_valid_o, valid_e);
        if (valid_e) begin
            chk("inst_addr", inst_addr_o, mq[0]);
            chk("inst_data", inst_o, mq[0] ^ DATA_KEY);
        end else begin
            chk("inst_nop", inst_o, NOP_W);
            chk("inst_addr_idle", inst_addr_o, 32'h0);
        end
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != m_epoch) stale++;
        req_e = !m_idle && (stale == 0) && !jump_en_i && ((pend.size() + mq.size()) < DEPTH);
        chk("imem_req", imem_req_o, req_e);
        if (req_e) chk("imem_addr", imem_addr_o, m_pc);
`ifdef INST_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched_o, m_pops);
        chk("perf_bubble", perf_bubble_o, m_bubbles);
`endif

        if (imem_req_o && imem_gnt_i) glog.push_back(imem_addr_o);
        if (imem_req_o && first_req_cyc < 0) first_req_cyc = cyc;
        if (inst_valid_o && !stall_i && !jump_en_i) begin
            plog.push_back(inst_addr_o);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            $display("cycle %0d: pop addr=%h inst=%h", cyc, inst_addr_o, inst_o);
        end

        // Model advance for the coming rising edge
        jeff   = jump_en_i && !m_idle;
        do_pop = !jump_en_i && valid_e && !stall_i;
        if (!m_idle && !stall_i && !valid_e) m_bubbles++;
        if (do_pop) begin
            void'(mq.pop_front());
            m_pops++;
        end
        if (req_e && imem_gnt_i) begin
            pend.push_back('{addr: m_pc, epoch: m_epoch, ready: cyc + $urandom_range(lat_lo, lat_hi)});
            m_pc = m_pc + 32'd4;
        end
        if (rv) begin
            r = pend.pop_front();
            if (!jeff && r.epoch == m_epoch) mq.push_back(r.addr);
        end
        if (jeff) begin
            mq.delete();
            m_epoch++;
            m_pc = {jump_en_i ? jump_addr_i[31:2] : m_pc[31:2], 2'b00};
        end
        m_idle = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_i       = 1'b0;
        stall_i       = 1'b0;
        jump_en_i     = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_addr", imem_addr_o, RST_PC);
        chk("rst_valid", inst_valid_o, 1'b0);
        chk("rst_inst", inst_o, NOP_W);
        chk("rst_inst_addr", inst_addr_o, 32'h0);
`ifdef INST_FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched_o, 32'h0);
        chk("rst_perf_bubble", perf_bubble_o, 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        pend.delete();
        mq.delete();
        m_pc      = RST_PC;
        m_idle    = 1'b1;
        m_pops    = 0;
        m_bubbles = 0;
        cyc       = 0;
    endtask

    task automatic run_random(input int n);
        bit j;
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5, $urandom(),
                 70, 1, 4, 1'b0, j);
        end
    endtask

    initial begin
        bit j;
        rst_n_i       = 1'b0;
        stall_i       = 1'b0;
        jump_en_i     = 1'b0;
        jump_addr_i   = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        m_epoch       = 0;
        first_req_cyc = -1;
        first_pop_cyc = -1;
        do_reset();

        // Free run: always granted, one-cycle response
        glog.delete();
        plog.delete();
        for (int i = 0; i < 40 && m_pops < 3; i++) step(1'b0, 1'b0, '0, 100, 1, 1, 1'b0, j);
        chk("free_run_three_pops", (m_pops == 3), 1'b1);
`ifdef INST_FETCH_PERF_EN
        chk("perf_fetched_after_3", perf_fetched_o, 32'd3);
`endif
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 100, 1, 1, 1'b0, j);
        chk("first_req_cycle", first_req_cyc, 32'd1);
        chk("first_pop_cycle", first_pop_cyc, 32'd3);
        chk("free_run_pops_logged", (plog.size() >= 3), 1'b1);
        if (plog.size() >= 3) begin
            chk("free_run_pop0", plog[0], 32'h0);
            chk("free_run_pop1", plog[1], 32'h4);
            chk("free_run_pop2", plog[2], 32'h8);
        end

        // Stall held with the buffer full, then released
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 100, 1, 1, 1'b0, j);
        chk("stall_fifo_full", inst_valid_o && (mq.size() == DEPTH), 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 100, 1, 1, 1'b0, j);

        // Redirect with two fetches outstanding
        for (int i = 0; i < 20 && pend.size() != 2; i++) step(1'b0, 1'b0, '0, 100, 3, 3, 1'b0, j);
        chk("redirect_two_outstanding", (pend.size() == 2), 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 100, 3, 3, 1'b0, j);
        glog.delete();
        plog.delete();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 100, 3, 3, 1'b0, j);
        chk("redirect_req_count", (glog.size() > 0 && plog.size() > 0), 1'b1);
        if (glog.size() > 0) chk("redirect_first_req", glog[0], 32'h0000_0100);
        if (plog.size() > 0) chk("redirect_first_pop", plog[0], 32'h0000_0100);

        // Redirect landing on a response while stalled
        j = 1'b0;
        for (int i = 0; i < 20 && !j; i++) step(1'b1, 1'b0, 32'h0000_0200, 100, 1, 1, 1'b1, j);
        chk("coincident_jump_seen", j, 1'b1);
        chk("coincident_fifo_empty", inst_valid_o, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 100, 1, 1, 1'b0, j);

        // Grant withheld, then slow responses
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 0, 4, 4, 1'b0, j);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 100, 4, 4, 1'b0, j);

        // PC wrap through the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 100, 1, 1, 1'b0, j);
        glog.delete();
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0, 100, 1, 1, 1'b0, j);
        chk("wrap_req_count", (glog.size() >= 3), 1'b1);
        if (glog.size() >= 3) begin
            chk("wrap_req0", glog[0], 32'hFFFF_FFF8);
            chk("wrap_req1", glog[1], 32'hFFFF_FFFC);
            chk("wrap_req2", glog[2], 32'h0000_0000);
        end

        // Random traffic, then reset mid-operation and more random traffic
        run_random(1500);
        do_reset();
        run_random(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
